// File: rtl/axis2ram.sv
// axis2ram: captures one frame of 2**ADDR_WIDTH stream beats into an internal
// simple dual-port RAM, then serves random-access reads to a consumer until the
// consumer re-arms the buffer for the next frame.
// Optional feature macro: AXIS2RAM_TLAST_EN adds dma_axi_tlst / frame_err
// end-of-frame checking.
module axis2ram #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  dma_axi_tvld,
   input  logic [DATA_WIDTH-1:0] dma_axi_tdat,
`ifdef AXIS2RAM_TLAST_EN
   input  logic                  dma_axi_tlst,
   output logic                  frame_err,
`endif
   output logic                  dma_axi_trdy,
   input  logic                  rearm,
   input  logic                  r_en,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_vld,
   output logic                  ram_rdy,
   output logic [15:0]           frame_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_wr_cnt;
   logic                    w_accept;
   logic                    w_last_beat;
   logic                    w_rd_issue;
   logic                    r_rd_vld1;
   logic [DATA_WIDTH-1:0]   r_ram_q;
   logic [DATA_WIDTH-1:0]   r_mem [0:(2**ADDR_WIDTH)-1];

   assign w_accept    = dma_axi_tvld && dma_axi_trdy;
   assign w_last_beat = (r_wr_cnt == LAST_ADDR);
   assign w_rd_issue  = r_en && (r_state == ST_READY);

   // Next-state and state-decoded outputs; trdy never depends on tvld.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      w_state_nxt  = r_state;
      dma_axi_trdy = 1'b0;
      ram_rdy      = 1'b0;
      case (r_state)
         ST_IDLE:  w_state_nxt = ST_FILL;
         ST_FILL: begin
            dma_axi_trdy = 1'b1;
            if (w_accept && w_last_beat) w_state_nxt = ST_READY;
         end
         ST_READY: begin
            ram_rdy = 1'b1;
            if (rearm) w_state_nxt = ST_FILL;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State register, write counter and completed-frame counter.
   always_ff @(posedge clk or negedge srstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!srstn) begin
         r_state   <= ST_IDLE;
         r_wr_cnt  <= '0;
         frame_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state != ST_FILL) begin
            r_wr_cnt <= '0;
         end else if (w_accept) begin
            r_wr_cnt <= r_wr_cnt + ADDR_ONE;
`ifdef AXIS2RAM_TLAST_EN
            // Early tlast discards the partial frame and restarts at address 0.
            if (dma_axi_tlst && !w_last_beat) r_wr_cnt <= '0;
`endif
         end
         if (w_accept && w_last_beat) frame_cnt <= frame_cnt + 16'd1;
      end
   end

`ifdef AXIS2RAM_TLAST_EN
   // Sticky error: tlast disagrees with the beat count (early or missing).
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         frame_err <= 1'b0;
      end else if (w_accept && (dma_axi_tlst != w_last_beat)) begin
         frame_err <= 1'b1;
      end
   end
`endif

   // Simple dual-port RAM: stream-side write port, consumer-side registered read.
   always_ff @(posedge clk) begin
      // NOTE: RAM and its read register are not reset so the array maps onto block RAM; r_rd_vld1 masks stale data.
      if (w_accept)   r_mem[r_wr_cnt] <= dma_axi_tdat;
      if (w_rd_issue) r_ram_q         <= r_mem[r_addr];
   end

   // Read pipeline valid tracking and output register; r_data holds between reads.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         r_rd_vld1 <= 1'b0;
         r_vld     <= 1'b0;
         r_data    <= '0;
      end else begin
         r_rd_vld1 <= w_rd_issue;
         r_vld     <= r_rd_vld1;
         if (r_rd_vld1) r_data <= r_ram_q;
      end
   end

endmodule

// File: doc/axis2ram.md
AXIS2RAM -- requirements
Module: axis2ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 13: RAM depth is 2**ADDR_WIDTH words; one frame is exactly 2**ADDR_WIDTH beats.
REQ-002 Parameter DATA_WIDTH, default 64: width of each stream beat and RAM word.
REQ-003 clk  input  1  single clock for all logic; rising edge.
REQ-004 srstn  input  1  reset, asynchronous assert, active-low.
REQ-005 dma_axi_tvld  input  1  stream beat valid from the DMA.
REQ-006 dma_axi_tdat  input  DATA_WIDTH  stream beat data.
REQ-007 dma_axi_trdy  output  1  block accepts a beat this cycle.
REQ-008 rearm  input  1  single-cycle pulse; consumer releases the buffer for the next frame.
REQ-009 r_en  input  1  consumer read request.
REQ-010 r_addr  input  ADDR_WIDTH  consumer read address.
REQ-011 r_data  output  DATA_WIDTH  read data.
REQ-012 r_vld  output  1  r_data valid this cycle.
REQ-013 ram_rdy  output  1  a complete frame is held in RAM.
REQ-014 frame_cnt  output  16  number of completed frames, wraps 0xFFFF->0.

Function
REQ-015 FSM states IDLE, FILL, READY; IDLE->FILL unconditionally on the first clock after reset release.
REQ-016 dma_axi_trdy SHALL equal 1 exactly while the state is FILL, decoded from the state register with no combinational path from dma_axi_tvld.
REQ-017 A beat is accepted when dma_axi_tvld and dma_axi_trdy are both 1; it is written at wr_cnt, and wr_cnt increments by 1.
REQ-018 wr_cnt starts at 0 on every entry to FILL; accepting the beat at wr_cnt = all-ones moves the FSM to READY on the next edge, and wr_cnt wraps to 0.
REQ-019 In READY: dma_axi_trdy=0, ram_rdy=1, and frame_cnt has incremented once for the frame, in the same edge as the transition.
REQ-020 A tvld gap in FILL stalls wr_cnt with no write; beat order and addresses are unaffected.
REQ-021 A read is issued when r_en=1 while in READY; r_data and r_vld=1 appear exactly 2 cycles later (registered RAM output plus output register).
REQ-022 r_en outside READY is ignored: no r_vld pulse results; r_data holds its last value.
REQ-023 Back-to-back reads are accepted every cycle, giving throughput of 1 word/cycle.
REQ-024 rearm in READY -> FILL on the next edge: ram_rdy=0, dma_axi_trdy=1. rearm in IDLE or FILL is ignored.
REQ-025 r_en and rearm in the same READY cycle: the read is accepted, then the FSM transitions; reads already in the pipeline still deliver r_vld on schedule.
REQ-026 RAM is simple dual-port, inferred internally, with the write port on the stream side and the read port on the consumer side; contents are not reset.

Reset
REQ-027 srstn=0 asynchronously forces: state IDLE, wr_cnt 0, dma_axi_trdy 0, ram_rdy 0, r_vld 0, r_data 0, frame_cnt 0, and clears the read pipeline.
REQ-028 Reset asserted mid-frame discards the partial frame; after release, filling restarts at address 0.

Configuration
REQ-029 Macro AXIS2RAM_TLAST_EN: when defined, it adds input dma_axi_tlst (1) and output frame_err (1, sticky, reset 0).
REQ-030 With the macro: an accepted beat with tlst=1 and wr_cnt != all-ones sets frame_err and resets wr_cnt to 0, which discards the frame and keeps the FSM in FILL.
REQ-031 With the macro: the final beat (wr_cnt = all-ones) with tlst=0 sets frame_err, but the frame still completes into READY.
REQ-032 Without the macro, the tlst and frame_err ports do not exist, and frame length is determined by count alone.

Verification (ADDR_WIDTH=4, DATA_WIDTH=64)
REQ-033 Send 16 beats, continuous tvld, data 0x100+i -> trdy drops the cycle after beat 15, ram_rdy=1, frame_cnt=1.
REQ-034 In READY, issue r_en on addr 0..15 back-to-back -> r_vld on 16 consecutive cycles starting 2 cycles later, with r_data=0x100..0x10F.
REQ-035 Send a frame with tvld gaps every other cycle, then read addr 7 -> r_data=0x107; r_en issued during FILL -> no r_vld.
REQ-036 Assert rearm together with r_en addr 3 -> r_vld with 0x103 after 2 cycles; trdy=1 the cycle after rearm; a second frame 0x200+i reads back correctly.
REQ-037 Assert srstn low after beat 5 -> all outputs reach reset values immediately; a new 16-beat frame 0x300+i reads back 0x300 at addr 0.
REQ-038 With AXIS2RAM_TLAST_EN: send tlst on beat 9 -> frame_err=1, ram_rdy stays 0; then 16 beats with tlst on beat 15 -> ram_rdy=1, and frame_err remains 1.
